// File: rtl/mont_sq_pkg.sv
// Shared types and helpers for the Montgomery squaring sequencer.
package mont_sq_pkg;

  localparam int unsigned W_DEF = 1026;

  typedef enum logic [2:0] {
    Idle,
    Sq,
    Rq,
    Rm,
    Sub
  } state_t;

  // Width of the per-phase wait counter; at least one bit so MULT_LAT == 1 still works.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mont_cond_sub.sv
// Conditional subtract: y = (a >= m) ? a - m : a. Used for the final reduction step.
module mont_cond_sub
  import mont_sq_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = (a_i >= m_i) ? (a_i - m_i) : a_i;
  end

endmodule

// File: rtl/mont_sq_sequencer.sv
// Repeated Montgomery squaring driving an external multicycle multiplier (p = x*y + accum).
// Define MONT_FINAL_SUB_EN to add a one-cycle conditional subtract per iteration.
module mont_sq_sequencer
  import mont_sq_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned ITER_W   = 32,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ITER_W-1:0] iterations,
  input  logic [W-1:0]      sq_in,
  input  logic [W-1:0]      modulus,
  input  logic [W-1:0]      mod_inv,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      sq_out,
  output logic [W-1:0]      mult_x,
  output logic [W-1:0]      mult_y,
  output logic [2*W-1:0]    mult_accum,
  input  logic [2*W-1:0]    mult_p
);

  localparam int unsigned   CntW    = clog2(MULT_LAT);
  localparam logic [CntW-1:0] CntLoad = CntW'(MULT_LAT - 1);

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [W-1:0]        cur_q, cur_d;
  logic [2*W-1:0]      t_q, t_d;
  logic [W-1:0]        m_q, m_d;
  logic [W-1:0]        minv_q, minv_d;
  logic [W-1:0]        x_q, x_d;
  logic [W-1:0]        y_q, y_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [W-1:0]        sq_out_q, sq_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                iter_end;
  logic [W-1:0]        next_cur;

`ifdef MONT_FINAL_SUB_EN
  logic [W-1:0] sub_res;

  mont_cond_sub #(
    .W(W)
  ) u_cond_sub (
    .a_i(cur_q),
    .m_i(m_q),
    .y_o(sub_res)
  );
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iter_d   = iter_q;
    cur_d    = cur_q;
    t_d      = t_q;
    m_d      = m_q;
    minv_d   = minv_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    sq_out_d = sq_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    iter_end = 1'b0;
    next_cur = '0;

    case (state_q)
      Idle: begin
        if (start) begin
          m_d    = modulus;
          minv_d = mod_inv;
          iter_d = iterations;
          cur_d  = sq_in;
          if (iterations == '0) begin
            done_d   = 1'b1;
            sq_out_d = sq_in;
          end else begin
            state_d = Sq;
            busy_d  = 1'b1;
            cnt_d   = CntLoad;
            x_d     = sq_in;
            y_d     = sq_in;
            acc_d   = '0;
          end
        end
      end
      Sq: begin
        if (cnt_q == '0) begin
          t_d     = mult_p;
          state_d = Rq;
          cnt_d   = CntLoad;
          x_d     = mult_p[W-1:0];
          y_d     = minv_q;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      Rq: begin
        if (cnt_q == '0) begin
          state_d = Rm;
          cnt_d   = CntLoad;
          x_d     = mult_p[W-1:0];
          y_d     = m_q;
          acc_d   = t_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      Rm: begin
        if (cnt_q == '0) begin
          // Low W bits of T + q*M are zero; the upper half is T/R.
          cur_d = mult_p[2*W-1:W];
`ifdef MONT_FINAL_SUB_EN
          state_d = Sub;
`else
          iter_end = 1'b1;
          next_cur = mult_p[2*W-1:W];
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef MONT_FINAL_SUB_EN
      Sub: begin
        cur_d    = sub_res;
        iter_end = 1'b1;
        next_cur = sub_res;
      end
`endif
      default: state_d = Idle;
    endcase

    if (iter_end) begin
      iter_d = iter_q - ITER_W'(1);
      if (iter_q == ITER_W'(1)) begin
        state_d  = Idle;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        sq_out_d = next_cur;
      end else begin
        state_d = Sq;
        cnt_d   = CntLoad;
        x_d     = next_cur;
        y_d     = next_cur;
        acc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= Idle;
      cnt_q    <= '0;
      iter_q   <= '0;
      cur_q    <= '0;
      t_q      <= '0;
      m_q      <= '0;
      minv_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      sq_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iter_q   <= iter_d;
      cur_q    <= cur_d;
      t_q      <= t_d;
      m_q      <= m_d;
      minv_q   <= minv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      sq_out_q <= sq_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sq_out     = sq_out_q;
  assign mult_x     = x_q;
  assign mult_y     = y_q;
  assign mult_accum = acc_q;

endmodule

// File: tb/tb_mont_sq_sequencer.sv
// Directed bench for mont_sq_sequencer with a behavioural x*y+accum multiplier.
module tb_mont_sq_sequencer;

  localparam int unsigned W        = 1026;
  localparam int unsigned ITER_W   = 32;
  localparam int unsigned MULT_LAT = 4;
  localparam int          LIMIT    = 200;
`ifdef MONT_FINAL_SUB_EN
  localparam int          ITER_LAT = 3 * MULT_LAT + 1;
`else
  localparam int          ITER_LAT = 3 * MULT_LAT;
`endif

  typedef logic [W-1:0]   wide_t;
  typedef logic [2*W-1:0] dw_t;

  typedef struct {
    wide_t       m;
    wide_t       a;
    int unsigned k;
    dw_t         exp_res;  // a^(2^k) mod M
  } vec_t;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ITER_W-1:0] iterations;
  wide_t             sq_in;
  wide_t             modulus;
  wide_t             mod_inv;
  logic              busy;
  logic              done;
  wide_t             sq_out;
  wide_t             mult_x;
  wide_t             mult_y;
  dw_t               mult_accum;
  dw_t               mult_p;

  int n_checks = 0;
  int n_err    = 0;

  mont_sq_sequencer #(
    .W(W),
    .ITER_W(ITER_W),
    .MULT_LAT(MULT_LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .iterations(iterations),
    .sq_in(sq_in),
    .modulus(modulus),
    .mod_inv(mod_inv),
    .busy(busy),
    .done(done),
    .sq_out(sq_out),
    .mult_x(mult_x),
    .mult_y(mult_y),
    .mult_accum(mult_accum),
    .mult_p(mult_p)
  );

  assign mult_p = dw_t'(mult_x) * dw_t'(mult_y) + mult_accum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input dw_t act, input dw_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ..%0h expected ..%0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  // Newton iteration for M^-1 mod 2^W, then negate.
  function automatic wide_t calc_minv(input wide_t m);
    wide_t inv;
    inv = wide_t'(1);
    for (int i = 0; i < 11; i++) inv = inv * (wide_t'(2) - m * inv);
    return ~inv + wide_t'(1);
  endfunction

  function automatic dw_t pow2k(input wide_t a, input wide_t m, input int unsigned k);
    dw_t v;
    dw_t mm;
    mm = dw_t'(m);
    v  = dw_t'(a) % mm;
    for (int unsigned i = 0; i < k; i++) v = (v * v) % mm;
    return v;
  endfunction

  // out * R^(2^k-1) mod M, which must equal a^(2^k) mod M.
  function automatic dw_t residue(input wide_t v, input wide_t m, input int unsigned k);
    dw_t mm;
    dw_t r;
    dw_t p;
    mm = dw_t'(m);
    r  = (dw_t'(1) << W) % mm;
    p  = dw_t'(1) % mm;
    for (int i = 0; i < (1 << k) - 1; i++) p = (p * r) % mm;
    return ((dw_t'(v) % mm) * p) % mm;
  endfunction

  function automatic vec_t mk(input wide_t m, input wide_t a, input int unsigned k, input dw_t e);
    vec_t v;
    v.m       = m;
    v.a       = a;
    v.k       = k;
    v.exp_res = e;
    return v;
  endfunction

  task automatic launch(input wide_t m, input wide_t a, input int unsigned k);
    modulus    = m;
    mod_inv    = calc_minv(m);
    sq_in      = a;
    iterations = ITER_W'(k);
    start      = 1'b1;
  endtask

  // Steps until done (bounded). poke > 0 pulses start with junk inputs in that cycle.
  task automatic wait_done(input int poke, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < LIMIT) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == poke) begin
        start      = 1'b1;
        sq_in      = wide_t'(3);
        iterations = '0;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic verify(input string tag, input wide_t m, input int unsigned k, input dw_t exp_res,
                        input int lat, input bit busy_ok);
    wide_t bound;
`ifdef MONT_FINAL_SUB_EN
    bound = (k == 0) ? (m << 1) : m;
`else
    bound = m << 1;
`endif
    check($sformatf("%s latency", tag), 128'(lat), 128'(int'(k) * ITER_LAT + 1));
    check($sformatf("%s busy", tag), 128'(busy_ok), 128'(1));
    check_wide($sformatf("%s residue", tag), residue(sq_out, m, k), exp_res);
    check($sformatf("%s range", tag), 128'(sq_out < bound), 128'(1));
  endtask

  initial begin
    vec_t  vecs[7];
    wide_t mbig;
    wide_t ra;
    int    lat;
    bit    bok;
    bit    saw_done;

    reset_n    = 1'b0;
    start      = 1'b0;
    iterations = '0;
    sq_in      = '0;
    modulus    = '0;
    mod_inv    = '0;
    step();
    step();
    reset_n = 1'b1;

    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset sq_out", 128'(sq_out), 128'(0));
    check("reset mult_x", 128'(mult_x), 128'(0));
    check("reset mult_y", 128'(mult_y), 128'(0));
    check("reset mult_accum", 128'(mult_accum), 128'(0));

    mbig = (wide_t'(1) << 1023) - wide_t'(1);
    ra   = '0;
    for (int i = 0; i < 33; i++) ra = (ra << 32) | wide_t'($urandom());
    ra = ra % mbig;

    vecs[0] = mk(wide_t'(13), wide_t'(2), 1, dw_t'(4));
    vecs[1] = mk(wide_t'(13), wide_t'(7), 0, dw_t'(7));
    vecs[2] = mk(wide_t'(13), wide_t'(20), 2, dw_t'(9));
    vecs[3] = mk(wide_t'(101), wide_t'(55), 3, dw_t'(19));
    vecs[4] = mk(mbig, ra, 5, pow2k(ra, mbig, 5));
    vecs[5] = mk(mbig, (mbig << 1) - wide_t'(1), 2, dw_t'(1));
    vecs[6] = mk(wide_t'(3), wide_t'(5), 4, dw_t'(1));

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].m, vecs[i].a, vecs[i].k);
      wait_done(0, lat, bok);
      verify($sformatf("vec%0d", i), vecs[i].m, vecs[i].k, vecs[i].exp_res, lat, bok);
      if (vecs[i].k == 0) check($sformatf("vec%0d passthrough", i), 128'(sq_out), 128'(vecs[i].a));
    end

    // Reset two cycles into the squaring phase.
    launch(wide_t'(13), wide_t'(2), 1);
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort busy", 128'(busy), 128'(0));
    check("abort done", 128'(done), 128'(0));
    check("abort sq_out", 128'(sq_out), 128'(0));
    check("abort mult_x", 128'(mult_x), 128'(0));
    check("abort mult_y", 128'(mult_y), 128'(0));
    check("abort mult_accum", 128'(mult_accum), 128'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("abort no done", 128'(saw_done), 128'(0));
    launch(wide_t'(13), wide_t'(2), 1);
    wait_done(0, lat, bok);
    verify("after abort", wide_t'(13), 1, dw_t'(4), lat, bok);

    // Start pulsed while busy must be ignored.
    launch(wide_t'(13), wide_t'(20), 2);
    wait_done(5, lat, bok);
    verify("start while busy", wide_t'(13), 2, dw_t'(9), lat, bok);

    // Back-to-back: second start issued in the done cycle of the first.
    launch(wide_t'(101), wide_t'(55), 3);
    wait_done(0, lat, bok);
    verify("b2b first", wide_t'(101), 3, dw_t'(19), lat, bok);
    launch(wide_t'(13), wide_t'(2), 1);
    step();
    check("b2b busy gap", 128'(busy), 128'(1));
    start = 1'b0;
    lat   = 1;
    bok   = 1'b1;
    while (!done && lat < LIMIT) begin
      if (!busy) bok = 1'b0;
      step();
      lat++;
    end
    if (busy) bok = 1'b0;
    verify("b2b second", wide_t'(13), 1, dw_t'(4), lat, bok);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
